// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, centre-sampling FSM and a
// single-byte valid/ready holding register with sticky framing/overrun flags.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 345,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_core,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;

  logic rx_s;
  logic consume;
  logic deliver;
  logic stop_fail;

  assign rx_s    = sync_q[1];
  assign consume = valid_q & rx_ready;

  always_comb begin
    sync_d      = {sync_q[0], rx};
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    deliver     = 1'b0;
    stop_fail   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = 16'd0;
        end
      end
      ST_START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = 16'd0;
          idx_d   = 3'(idx_q + 3'd1);
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_fail = 1'b1;
            state_d   = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear first so that an error arriving in the same cycle still sticks.
    if (err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (stop_fail) frame_err_d = 1'b1;

    if (deliver) begin
      if (!valid_q || consume) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
